// File: rtl/axilite_adder_ctrl.sv
// axilite_adder_ctrl: AXI4-Lite master that runs one add command against the
// memory-mapped adder slave. It writes A and B, reads back the sum and the
// overflow flag, then presents a single response to the requester.
// Only a 32-bit data path is meaningful; C_M_AXI_DATA_WIDTH exists for
// interface compatibility.
module axilite_adder_ctrl #(
   parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_BASEADDR  = '0,
   parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned                  C_TIMEOUT          = 64
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   // requester side
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [31:0]                   cmd_a,
   input  logic [31:0]                   cmd_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [31:0]                   rsp_sum,
   output logic                          rsp_ovf,
   output logic [1:0]                    rsp_err,
   // AXI4-Lite master
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int CW = $clog2(C_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT - 1);

   localparam logic [AW-1:0] ADDR_A   = C_M_AXI_BASEADDR;
   localparam logic [AW-1:0] ADDR_B   = C_M_AXI_BASEADDR + AW'(4);
   localparam logic [AW-1:0] ADDR_SUM = C_M_AXI_BASEADDR + AW'(8);
   localparam logic [AW-1:0] ADDR_OVF = C_M_AXI_BASEADDR + AW'(12);

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_SLV = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_SUM, RD_OVF, RESP} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          aw_done_reg, aw_done_next;
   logic          w_done_reg, w_done_next;
   logic          ar_done_reg, ar_done_next;
   logic [31:0]   a_reg, a_next;
   logic [31:0]   b_reg, b_next;
   logic [31:0]   sum_reg, sum_next;
   logic          ovf_reg, ovf_next;
   logic [1:0]    err_reg, err_next;

   logic in_wr, in_rd;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs, timed_out;

   assign in_wr     = (state_reg == WR_A) || (state_reg == WR_B);
   assign in_rd     = (state_reg == RD_SUM) || (state_reg == RD_OVF);
   assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
   assign ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
   assign b_hs      = M_AXI_BVALID && M_AXI_BREADY;
   assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
   assign timed_out = (cnt_reg == CNT_LAST);

   assign rsp_sum = sum_reg;
   assign rsp_ovf = ovf_reg;
   assign rsp_err = err_reg;

   // Bus and handshake outputs decoded from the state and per-channel done flags
   always_comb begin
      cmd_ready     = (state_reg == IDLE);
      rsp_valid     = (state_reg == RESP);
      M_AXI_AWVALID = in_wr && !aw_done_reg;
      M_AXI_WVALID  = in_wr && !w_done_reg;
      M_AXI_BREADY  = in_wr && aw_done_reg && w_done_reg;
      M_AXI_ARVALID = in_rd && !ar_done_reg;
      M_AXI_RREADY  = in_rd && ar_done_reg;
      M_AXI_AWADDR  = '0;
      M_AXI_WDATA   = '0;
      M_AXI_ARADDR  = '0;
      case (state_reg)
         WR_A: begin
            M_AXI_AWADDR = ADDR_A;
            M_AXI_WDATA  = DW'(a_reg);
         end
         WR_B: begin
            M_AXI_AWADDR = ADDR_B;
            M_AXI_WDATA  = DW'(b_reg);
         end
         RD_SUM:  M_AXI_ARADDR = ADDR_SUM;
         RD_OVF:  M_AXI_ARADDR = ADDR_OVF;
         default: ;
      endcase
   end

   // Next-state, result capture and per-state timeout; any state change
   // clears the counter and the channel done flags
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      aw_done_next = aw_done_reg || aw_hs;
      w_done_next  = w_done_reg || w_hs;
      ar_done_next = ar_done_reg || ar_hs;
      a_next       = a_reg;
      b_next       = b_reg;
      sum_next     = sum_reg;
      ovf_next     = ovf_reg;
      err_next     = err_reg;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               a_next     = cmd_a;
               b_next     = cmd_b;
               sum_next   = '0;
               ovf_next   = 1'b0;
               err_next   = ERR_OK;
               state_next = WR_A;
            end
         end
         WR_A, WR_B: begin
            cnt_next = cnt_reg + 1'b1;
            if (b_hs) begin
               if (M_AXI_BRESP != 2'b00) begin
                  err_next   = ERR_SLV;
                  sum_next   = '0;
                  ovf_next   = 1'b0;
                  state_next = RESP;
               end else begin
                  state_next = (state_reg == WR_A) ? WR_B : RD_SUM;
               end
            end else if (timed_out) begin
               // abort without completing the handshake; VALID drops unserviced
               err_next   = ERR_TMO;
               sum_next   = '0;
               ovf_next   = 1'b0;
               state_next = RESP;
            end
         end
         RD_SUM, RD_OVF: begin
            cnt_next = cnt_reg + 1'b1;
            if (r_hs) begin
               if (M_AXI_RRESP != 2'b00) begin
                  err_next   = ERR_SLV;
                  sum_next   = '0;
                  ovf_next   = 1'b0;
                  state_next = RESP;
               end else if (state_reg == RD_SUM) begin
                  sum_next   = M_AXI_RDATA[31:0];
                  state_next = RD_OVF;
               end else begin
                  ovf_next   = |M_AXI_RDATA;
                  state_next = RESP;
               end
            end else if (timed_out) begin
               err_next   = ERR_TMO;
               sum_next   = '0;
               ovf_next   = 1'b0;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (state_next != state_reg) begin
         cnt_next     = '0;
         aw_done_next = 1'b0;
         w_done_next  = 1'b0;
         ar_done_next = 1'b0;
      end
   end

   // State and datapath registers; asynchronous assert, synchronous release
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         ar_done_reg <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         sum_reg     <= '0;
         ovf_reg     <= 1'b0;
         err_reg     <= ERR_OK;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         aw_done_reg <= aw_done_next;
         w_done_reg  <= w_done_next;
         ar_done_reg <= ar_done_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         sum_reg     <= sum_next;
         ovf_reg     <= ovf_next;
         err_reg     <= err_next;
      end
   end

endmodule
